// File: rtl/garage_gate_sensor.sv
// Entry/exit lane sensor: synchronizes and debounces two light beams, tracks a vehicle
// through the beam pair, drives the barrier and emits park_in/park_out pulses.
// Optional passage timeout with sticky fault is built when GARAGE_GATE_TIMEOUT_EN is defined.
module garage_gate_sensor #(
    parameter int DEB_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       beam_a,
    input  logic       beam_b,
    input  logic       full,
    input  logic       fault_clr,
    output logic       park_in,
    output logic       park_out,
    output logic       gate_open,
    output logic       deny,
    output logic       fault,
    output logic [2:0] state
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] IN1  = 3'd1;
    localparam logic [2:0] IN2  = 3'd2;
    localparam logic [2:0] IN3  = 3'd3;
    localparam logic [2:0] OUT1 = 3'd4;
    localparam logic [2:0] OUT2 = 3'd5;
    localparam logic [2:0] OUT3 = 3'd6;
    localparam logic [2:0] DENY = 3'd7;

    localparam int DEB_W = $clog2(DEB_CYCLES) + 1;

    // Bit 1 carries beam A (outer), bit 0 beam B (inner).
    logic [1:0] beam_raw;
    logic [1:0] beam_d;

    assign beam_raw = {beam_a, beam_b};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_beam
            logic             meta_reg;
            logic             sync_reg;
            logic             deb_reg;
            logic [DEB_W-1:0] cnt_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                    deb_reg  <= 1'b0;
                    cnt_reg  <= '0;
                end else begin
                    meta_reg <= beam_raw[gi];
                    sync_reg <= meta_reg;
                    if (sync_reg == deb_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
                        deb_reg <= sync_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign beam_d[gi] = deb_reg;
        end
    endgenerate

    logic [2:0] state_reg;
    logic [2:0] state_next;
    logic       park_in_reg;
    logic       park_in_next;
    logic       park_out_reg;
    logic       park_out_next;
    logic       active;
    logic       timeout_hit;

    assign active = (state_reg != IDLE) && (state_reg != DENY);

    always_comb begin
        state_next    = state_reg;
        park_in_next  = 1'b0;
        park_out_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (beam_d == 2'b10)      state_next = full ? DENY : IN1;
                else if (beam_d == 2'b01) state_next = OUT1;
            end
            IN1: begin
                if (beam_d == 2'b11)      state_next = IN2;
                else if (beam_d == 2'b01) state_next = IN3;
                else if (beam_d == 2'b00) state_next = IDLE;
            end
            IN2: begin
                if (beam_d == 2'b01)      state_next = IN3;
                else if (beam_d == 2'b10) state_next = IN1;
                else if (beam_d == 2'b00) state_next = IDLE;
            end
            IN3: begin
                if (beam_d == 2'b00) begin
                    state_next   = IDLE;
                    park_in_next = 1'b1;
                end else if (beam_d == 2'b11) begin
                    state_next = IN2;
                end else if (beam_d == 2'b10) begin
                    state_next = IN1;
                end
            end
            OUT1: begin
                if (beam_d == 2'b11)      state_next = OUT2;
                else if (beam_d == 2'b10) state_next = OUT3;
                else if (beam_d == 2'b00) state_next = IDLE;
            end
            OUT2: begin
                if (beam_d == 2'b10)      state_next = OUT3;
                else if (beam_d == 2'b01) state_next = OUT1;
                else if (beam_d == 2'b00) state_next = IDLE;
            end
            OUT3: begin
                if (beam_d == 2'b00) begin
                    state_next    = IDLE;
                    park_out_next = 1'b1;
                end else if (beam_d == 2'b11) begin
                    state_next = OUT2;
                end else if (beam_d == 2'b01) begin
                    state_next = OUT1;
                end
            end
            default: begin
                if (beam_d == 2'b00) state_next = IDLE;
            end
        endcase
        // A stalled passage is abandoned without an event.
        if (timeout_hit) begin
            state_next    = IDLE;
            park_in_next  = 1'b0;
            park_out_next = 1'b0;
        end
    end

`ifdef GARAGE_GATE_TIMEOUT_EN
    localparam int DWELL_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [DWELL_W-1:0] dwell_reg;
    logic               fault_reg;

    // Fires on the edge where the dwell count would reach TIMEOUT_CYCLES.
    assign timeout_hit = active && (dwell_reg == DWELL_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_reg <= '0;
            fault_reg <= 1'b0;
        end else begin
            if ((state_next != state_reg) || !active) begin
                dwell_reg <= '0;
            end else if (dwell_reg != DWELL_W'(TIMEOUT_CYCLES)) begin
                dwell_reg <= dwell_reg + 1'b1;
            end
            if (timeout_hit) begin
                fault_reg <= 1'b1;
            end else if (fault_clr) begin
                fault_reg <= 1'b0;
            end
        end
    end

    assign fault = fault_reg;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic unused_fault_clr;

    assign unused_fault_clr = fault_clr;
    assign timeout_hit      = 1'b0;
    assign fault            = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            park_in_reg  <= 1'b0;
            park_out_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            park_in_reg  <= park_in_next;
            park_out_reg <= park_out_next;
        end
    end

    assign state     = state_reg;
    assign park_in   = park_in_reg;
    assign park_out  = park_out_reg;
    assign gate_open = active;
    assign deny      = (state_reg == DENY);

endmodule

// File: tb/tb_garage_gate_sensor.sv
// Directed bench for garage_gate_sensor: a passage-level model checked every cycle,
// plus literal expectations for pulse latency, timeout dwell and reset behaviour.
module tb_garage_gate_sensor;

    localparam int DEB = 4;
    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       beam_a = 1'b0;
    logic       beam_b = 1'b0;
    logic       full = 1'b0;
    logic       fault_clr = 1'b0;
    logic       park_in;
    logic       park_out;
    logic       gate_open;
    logic       deny;
    logic       fault;
    logic [2:0] state;

    garage_gate_sensor #(
        .DEB_CYCLES(DEB),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .beam_a(beam_a),
        .beam_b(beam_b),
        .full(full),
        .fault_clr(fault_clr),
        .park_in(park_in),
        .park_out(park_out),
        .gate_open(gate_open),
        .deny(deny),
        .fault(fault),
        .state(state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int in_cnt = 0;
    int out_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Passage model: direction plus phase (1 = lead beam only, 2 = both, 3 = trail beam only).
    int edge_no = 0;
    int entry_edge = 0;
    bit ha[DEB+1];
    bit hb[DEB+1];
    bit m_a = 0, m_b = 0;
    int m_phase = 0;
    bit m_dir = 0, m_deny = 0, m_fault = 0, m_pin = 0, m_pout = 0;

    function automatic int m_code();
        if (m_deny) return 7;
        if (m_phase == 0) return 0;
        return (m_dir ? 3 : 0) + m_phase;
    endfunction

    function automatic int phase_of(input bit dir, input bit a, input bit b);
        bit lead, trail;
        lead  = dir ? b : a;
        trail = dir ? a : b;
        if (lead && !trail) return 1;
        if (lead && trail) return 2;
        return 3;
    endfunction

    initial begin
        int prev_code, ones_a, ones_b;
        bit timed_out;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int i = 0; i <= DEB; i++) begin
                    ha[i] = 0;
                    hb[i] = 0;
                end
                m_a = 0; m_b = 0; m_phase = 0; m_dir = 0; m_deny = 0;
                m_fault = 0; m_pin = 0; m_pout = 0;
                entry_edge = edge_no;
            end else begin
                edge_no++;
                prev_code = m_code();
                m_pin = 0;
                m_pout = 0;
                timed_out = 0;
`ifdef GARAGE_GATE_TIMEOUT_EN
                timed_out = (m_phase != 0) && !m_deny && (edge_no - entry_edge == TMO);
`endif
                if (timed_out) begin
                    m_phase = 0;
                    m_fault = 1;
                end else if (m_deny) begin
                    if (!m_a && !m_b) m_deny = 0;
                end else if (m_phase == 0) begin
                    if (m_a && !m_b) begin
                        if (full) m_deny = 1;
                        else begin m_dir = 0; m_phase = 1; end
                    end else if (!m_a && m_b) begin
                        m_dir = 1;
                        m_phase = 1;
                    end
                end else if (!m_a && !m_b) begin
                    if (m_phase == 3) begin
                        if (m_dir) m_pout = 1;
                        else m_pin = 1;
                    end
                    m_phase = 0;
                end else begin
                    m_phase = phase_of(m_dir, m_a, m_b);
                end
                if (!timed_out && fault_clr) m_fault = 0;
                if (m_code() != prev_code) entry_edge = edge_no;
                // A debounced beam follows once the last DEB synchronized samples agree.
                ones_a = 0;
                ones_b = 0;
                for (int i = 1; i <= DEB; i++) begin
                    ones_a += int'(ha[i]);
                    ones_b += int'(hb[i]);
                end
                if (ones_a == DEB) m_a = 1; else if (ones_a == 0) m_a = 0;
                if (ones_b == DEB) m_b = 1; else if (ones_b == 0) m_b = 0;
                for (int i = DEB; i > 0; i--) begin
                    ha[i] = ha[i-1];
                    hb[i] = hb[i-1];
                end
                ha[0] = beam_a;
                hb[0] = beam_b;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("state", 32'(state), 32'(m_code()));
            chk("park_in", 32'(park_in), 32'(m_pin));
            chk("park_out", 32'(park_out), 32'(m_pout));
            chk("gate_open", 32'(gate_open), 32'((m_phase != 0) && !m_deny));
            chk("deny", 32'(deny), 32'(m_deny));
            chk("fault", 32'(fault), 32'(m_fault));
            chk("no_both_pulses", 32'(park_in & park_out), 32'd0);
            if (park_in === 1'b1) in_cnt++;
            if (park_out === 1'b1) out_cnt++;
        end
    end

    task automatic hold(input bit a, input bit b, input bit f, input int n);
        beam_a = a;
        beam_b = b;
        full = f;
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c_in, c_out, first, t2, t0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_gate", 32'(gate_open), 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_deny", 32'(deny), 32'd0);
        $display("reset released: state=%0d", state);

        // Clean entry
        c_in = in_cnt;
        hold(1, 0, 0, 10); chk("entry_in1", 32'(state), 32'd1); chk("entry_gate", 32'(gate_open), 32'd1);
        hold(1, 1, 0, 10); chk("entry_in2", 32'(state), 32'd2);
        hold(0, 1, 0, 10); chk("entry_in3", 32'(state), 32'd3);
        beam_a = 0;
        beam_b = 0;
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (park_in && first < 0) first = i;
        end
        #1;
        chk("entry_pulse_edge", 32'(first), 32'd7);
        chk("entry_pulse_count", 32'(in_cnt - c_in), 32'd1);
        chk("entry_idle", 32'(state), 32'd0);
        $display("clean entry: park_in at edge %0d after clear", first);

        // Exit, then an entry starting right behind it
        c_in = in_cnt;
        c_out = out_cnt;
        hold(0, 1, 0, 10); chk("exit_out1", 32'(state), 32'd4);
        hold(1, 1, 0, 10); chk("exit_out2", 32'(state), 32'd5);
        hold(1, 0, 0, 10); chk("exit_out3", 32'(state), 32'd6);
        hold(0, 0, 0, 4);
        hold(1, 0, 0, 10);
        hold(1, 1, 0, 10);
        hold(0, 1, 0, 10);
        hold(0, 0, 0, 10);
        chk("b2b_out_count", 32'(out_cnt - c_out), 32'd1);
        chk("b2b_in_count", 32'(in_cnt - c_in), 32'd1);
        $display("exit then entry: park_out=%0d park_in=%0d", out_cnt - c_out, in_cnt - c_in);

        // Glitch and abort
        c_in = in_cnt;
        hold(1, 0, 0, 3);
        hold(0, 0, 0, 10); chk("glitch_idle", 32'(state), 32'd0);
        hold(1, 0, 0, 10); chk("abort_in1", 32'(state), 32'd1);
        hold(0, 0, 0, 10); chk("abort_idle", 32'(state), 32'd0);
        chk("abort_no_pulse", 32'(in_cnt - c_in), 32'd0);
        $display("glitch and abort: state=%0d", state);

        // Full garage
        c_in = in_cnt;
        hold(1, 0, 1, 10);
        chk("full_deny_state", 32'(state), 32'd7);
        chk("full_deny", 32'(deny), 32'd1);
        chk("full_gate", 32'(gate_open), 32'd0);
        hold(1, 0, 0, 10); chk("full_drop_stays", 32'(state), 32'd7);
        hold(0, 0, 0, 10); chk("full_release", 32'(state), 32'd0);
        chk("full_no_pulse", 32'(in_cnt - c_in), 32'd0);
        $display("full: deny then idle, state=%0d", state);

        // Stalled passage
        c_in = in_cnt;
        hold(1, 0, 0, 10); chk("tmo_in1", 32'(state), 32'd1);
        beam_a = 1;
        beam_b = 1;
        t2 = -1;
        t0 = -1;
        for (int i = 1; i <= 150; i++) begin
            @(posedge clk);
            #1;
            if (state == 3'd2 && t2 < 0) t2 = i;
            if (t2 >= 0 && t0 < 0 && state == 3'd0) t0 = i;
        end
        #1;
        chk("tmo_in2_edge", 32'(t2), 32'd7);
`ifdef GARAGE_GATE_TIMEOUT_EN
        chk("tmo_dwell", 32'(t0 - t2), 32'(TMO));
        chk("tmo_fault_set", 32'(fault), 32'd1);
`else
        chk("tmo_disabled_state", 32'(state), 32'd2);
        chk("tmo_disabled_fault", 32'(fault), 32'd0);
`endif
        chk("tmo_no_pulse", 32'(in_cnt - c_in), 32'd0);
        fault_clr = 1;
        @(posedge clk);
        #2 fault_clr = 0;
        chk("tmo_fault_clr", 32'(fault), 32'd0);
        hold(0, 0, 0, 10); chk("tmo_idle", 32'(state), 32'd0);
        $display("timeout: in2 at edge %0d, idle at edge %0d", t2, t0);

        // Reset in the middle of an entry
        hold(1, 0, 0, 10);
        hold(1, 1, 0, 10);
        hold(0, 1, 0, 10); chk("rst_in3", 32'(state), 32'd3);
        c_in = in_cnt;
        reset = 1;
        beam_b = 0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_gate", 32'(gate_open), 32'd0);
        chk("rst_park_in", 32'(park_in), 32'd0);
        chk("rst_deny", 32'(deny), 32'd0);
        repeat (3) @(posedge clk);
        #2 reset = 0;
        hold(0, 0, 0, 15);
        chk("rst_no_pulse", 32'(in_cnt - c_in), 32'd0);
        chk("rst_idle", 32'(state), 32'd0);
        $display("reset mid-passage: state=%0d", state);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
